// File: rtl/led_pkg.sv
// Shared types and helpers for the LED matrix frame sequencer.
// Matrix geometry, sequencer states and pattern-index arithmetic.
package led_pkg;

   localparam int NUM_COL = 16;
   localparam int COL_W   = 4;
   localparam int PAT_W   = 3;

   typedef enum logic [1:0] {
      IDLE,
      PLAY,
      PAUSE
   } seq_state_t;

   // Wrap-around pattern step in either direction
   function automatic logic [PAT_W-1:0] next_pat(
      input logic [PAT_W-1:0] idx,
      input logic             dir,
      input int unsigned      num_pat
   );
      logic [PAT_W-1:0] last;
      last = PAT_W'(num_pat - 1);
      if (!dir)
         return (idx == last) ? '0 : idx + PAT_W'(1);
      else
         return (idx == '0) ? last : idx - PAT_W'(1);
   endfunction

endpackage

// File: rtl/led_scan_tick.sv
// Column-rate prescaler and column counter for the LED scanner.
// Runs freely in every sequencer state so the display never stalls.
module led_scan_tick
   import led_pkg::*;
#(
   parameter int unsigned PRESCALE = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             scan_tick,
   output logic [COL_W-1:0] col,
   output logic             frame_end
);

   localparam logic [15:0] CNT_LAST = 16'(PRESCALE - 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_COL - 1);

   logic [15:0]      cnt_q;
   logic [15:0]      cnt_d;
   logic             tick_q;
   logic [COL_W-1:0] col_q;

   // Prescale count wraps after PRESCALE-1
   always_comb begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 16'd1;
   end

   // Registered tick one cycle after the last count; column steps on tick
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
         col_q  <= '0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= (cnt_q == CNT_LAST);
         if (tick_q)
            col_q <= col_q + COL_W'(1);
      end
   end

   assign scan_tick = tick_q;
   assign col       = col_q;
   assign frame_end = tick_q && (col_q == COL_LAST);

endmodule

// File: rtl/led_frame_sequencer.sv
// Pattern sequencer for the 16x16 LED matrix scanner.
// Play/pause/step control; pattern changes land only on frame edges.
module led_frame_sequencer
   import led_pkg::*;
#(
   parameter int unsigned PRESCALE = 4,
   parameter int unsigned DWELL    = 8,
   parameter int unsigned NUM_PAT  = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             pause,
   input  logic             step,
   input  logic             dir,
   output logic [PAT_W-1:0] pat_sel,
   output logic [COL_W-1:0] col,
   output logic             scan_tick,
   output logic             frame_end,
   output logic             playing
);

   localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

   seq_state_t       state_q;
   logic [7:0]       dwell_q;
   logic             pend_q;
   logic [PAT_W-1:0] pat_q;
   logic             play_q;
   logic [PAT_W-1:0] pat_d;
   logic             fe;

   led_scan_tick #(
      .PRESCALE (PRESCALE)
   ) u_scan (
      .clk       (clk),
      .rst_n     (rst_n),
      .scan_tick (scan_tick),
      .col       (col),
      .frame_end (fe)
   );

   // Candidate index if an advance is committed this cycle
   always_comb begin
      pat_d = next_pat(pat_q, dir, NUM_PAT);
   end

   // Sequencer FSM: frame-boundary commit uses the pre-transition state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         dwell_q <= '0;
         pend_q  <= 1'b0;
         pat_q   <= '0;
         play_q  <= 1'b0;
      end else begin
         if (fe) begin
            if (state_q == PLAY) begin
               if (dwell_q == DWELL_LAST) begin
                  pat_q   <= pat_d;
                  dwell_q <= '0;
               end else begin
                  dwell_q <= dwell_q + 8'd1;
               end
            end else if (pend_q) begin
               pat_q  <= pat_d;
               pend_q <= 1'b0;
            end
         end
         if (pause && state_q != IDLE) begin
            state_q <= PAUSE;
            play_q  <= 1'b0;
         end else if (start && state_q != PLAY) begin
            state_q <= PLAY;
            play_q  <= 1'b1;
            pend_q  <= 1'b0;
         end else if (step && state_q != PLAY) begin
            pend_q <= 1'b1;
         end
      end
   end

   assign pat_sel   = pat_q;
   assign frame_end = fe;
   assign playing   = play_q;

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Directed bench for led_frame_sequencer (PRESCALE=4, DWELL=2, NUM_PAT=5).
// Cycle 0 is the first cycle with reset released.
module tb_led_frame_sequencer;

   typedef struct {
      int       cyc;
      logic     st;
      logic     pa;
      logic     sp;
      logic     dr;
      int       pat;
      logic     ply;
   } rec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       pause = 1'b0;
   logic       step = 1'b0;
   logic       dir = 1'b0;
   logic [2:0] pat_sel;
   logic [3:0] col;
   logic       scan_tick;
   logic       frame_end;
   logic       playing;

   int   checks = 0;
   int   errors = 0;
   int   cur = 0;
   int   ri = 0;
   rec_t tab[$];

   led_frame_sequencer #(
      .PRESCALE (4),
      .DWELL    (2),
      .NUM_PAT  (5)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .pause     (pause),
      .step      (step),
      .dir       (dir),
      .pat_sel   (pat_sel),
      .col       (col),
      .scan_tick (scan_tick),
      .frame_end (frame_end),
      .playing   (playing)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cur, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      start = 1'b0;
      pause = 1'b0;
      step  = 1'b0;
   endtask

   // Expected scan outputs derived from the cycle number alone
   task automatic chk_scan(input int c);
      logic       et;
      logic [3:0] ec;
      logic       ef;
      et = (c != 0) && (c % 4 == 0);
      ec = (c == 0) ? 4'd0 : 4'(((c - 1) / 4) % 16);
      ef = et && (ec == 4'd15);
      chk("scan_tick", 32'(scan_tick), 32'(et));
      chk("col", 32'(col), 32'(ec));
      chk("frame_end", 32'(frame_end), 32'(ef));
   endtask

   task automatic add(input int c, input logic st, input logic pa,
                      input logic sp, input logic dr, input int pat,
                      input logic ply);
      rec_t r;
      r.cyc = c;
      r.st  = st;
      r.pa  = pa;
      r.sp  = sp;
      r.dr  = dr;
      r.pat = pat;
      r.ply = ply;
      tab.push_back(r);
   endtask

   initial begin
      // cyc, start, pause, step, dir, exp pat_sel, exp playing
      add(0,    0, 0, 0, 0, 0, 0);
      add(5,    0, 1, 0, 0, 0, 0);
      add(6,    0, 0, 0, 0, 0, 0);
      add(10,   1, 0, 0, 0, 0, 0);
      add(11,   0, 0, 0, 0, 0, 1);
      add(128,  0, 0, 0, 0, 0, 1);
      add(129,  0, 0, 0, 0, 1, 1);
      add(256,  0, 0, 0, 0, 1, 1);
      add(257,  0, 0, 0, 0, 2, 1);
      add(385,  0, 0, 0, 0, 3, 1);
      add(513,  0, 0, 0, 0, 4, 1);
      add(640,  0, 0, 0, 0, 4, 1);
      add(641,  0, 0, 0, 1, 0, 1);
      add(768,  0, 0, 0, 1, 0, 1);
      add(769,  0, 0, 0, 1, 4, 1);
      add(850,  0, 1, 0, 1, 4, 1);
      add(851,  0, 0, 0, 1, 4, 0);
      add(1000, 0, 0, 0, 1, 4, 0);
      add(1150, 1, 0, 0, 1, 4, 0);
      add(1151, 0, 0, 0, 1, 4, 1);
      add(1152, 0, 0, 0, 1, 4, 1);
      add(1153, 0, 0, 0, 1, 3, 1);
      add(1280, 0, 0, 0, 1, 3, 1);
      add(1281, 0, 0, 0, 1, 2, 1);
      add(1290, 0, 1, 0, 1, 2, 1);
      add(1300, 0, 0, 1, 1, 2, 0);
      add(1310, 0, 0, 1, 1, 2, 0);
      add(1320, 0, 0, 1, 1, 2, 0);
      add(1344, 0, 0, 0, 1, 2, 0);
      add(1345, 0, 0, 0, 1, 1, 0);
      add(1408, 0, 0, 1, 1, 1, 0);
      add(1409, 0, 0, 0, 1, 1, 0);
      add(1472, 0, 0, 0, 1, 1, 0);
      add(1473, 0, 0, 0, 1, 0, 0);
      add(1480, 1, 0, 0, 0, 0, 0);
      add(1500, 0, 0, 1, 0, 0, 1);
      add(1600, 0, 0, 0, 0, 0, 1);
      add(1601, 0, 0, 0, 0, 1, 1);
      add(1729, 0, 0, 0, 0, 2, 1);
      add(1857, 0, 0, 0, 0, 3, 1);

      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      for (int c = 0; c < 1870; c++) begin
         cur = c;
         chk_scan(c);
         if (ri < tab.size() && tab[ri].cyc == c) begin
            chk("pat_sel", 32'(pat_sel), 32'(tab[ri].pat));
            chk("playing", 32'(playing), 32'(tab[ri].ply));
            start = tab[ri].st;
            pause = tab[ri].pa;
            step  = tab[ri].sp;
            dir   = tab[ri].dr;
            ri++;
         end
         tick();
      end
      cur = 1870;
      chk("table_done", 32'(ri), 32'(tab.size()));
      chk_scan(1870);
      chk("pat_sel", 32'(pat_sel), 32'd3);
      chk("playing", 32'(playing), 32'd1);

      // One-cycle reset in the middle of a PLAY frame
      rst_n = 1'b0;
      tick();
      chk("rst_pat_sel", 32'(pat_sel), 32'd0);
      chk("rst_col", 32'(col), 32'd0);
      chk("rst_playing", 32'(playing), 32'd0);
      chk("rst_scan_tick", 32'(scan_tick), 32'd0);
      chk("rst_frame_end", 32'(frame_end), 32'd0);
      rst_n = 1'b1;

      // Idle run after reset: free scan, pattern stays put
      for (int c = 0; c < 200; c++) begin
         cur = c;
         chk_scan(c);
         chk("idle_pat_sel", 32'(pat_sel), 32'd0);
         chk("idle_playing", 32'(playing), 32'd0);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
